// File: rtl/game_pkg.sv
// Shared definitions for the game tick scheduler: state encoding, board
// defaults and the run/pause/stop transition function.
package game_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN   = 2'b01,
        ST_PAUSE = 2'b10
    } state_e;

    // 50 MHz board clock divided down to a 100 Hz base tick
    localparam int PRESCALE_M_DEFAULT = 500000;
    localparam int PRESCALE_N_DEFAULT = 19;

    // stop wins over pause, pause over start; commands not legal in a state are dropped
    function automatic state_e next_state(state_e cur, logic start, logic pause, logic stop);
        state_e nxt;
        nxt = cur;
        if (stop) begin
            nxt = ST_IDLE;
        end else begin
            case (cur)
                ST_IDLE:  if (start) nxt = ST_RUN;
                ST_RUN:   if (pause) nxt = ST_PAUSE;
                ST_PAUSE: if (start) nxt = ST_RUN;
                default:  nxt = ST_IDLE;
            endcase
        end
        return nxt;
    endfunction

endpackage

// File: rtl/game_tick_scheduler_if.sv
// Command, configuration and tick-output bundle of the game tick scheduler.
interface game_tick_scheduler_if #(
    parameter int CH = 4,
    parameter int PW = 8
);
    import game_pkg::*;

    localparam int CW = (CH > 1) ? $clog2(CH) : 1;

    logic          start;
    logic          pause;
    logic          stop;
    logic          step;
    logic          cfg_we;
    logic [CW-1:0] cfg_ch;
    logic [PW-1:0] cfg_period;
    state_e        state;
    logic          base_tick;
    logic [CH-1:0] tick;

    modport master (
        output start, pause, stop, step, cfg_we, cfg_ch, cfg_period,
        input  state, base_tick, tick
    );

    modport slave (
        input  start, pause, stop, step, cfg_we, cfg_ch, cfg_period,
        output state, base_tick, tick
    );

endinterface

// File: rtl/game_tick_scheduler_tick_channel.sv
// One programmable tick channel: period register, base-event counter and
// registered expiry pulse.
module tick_channel #(
    parameter int PW = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          base_event,
    input  logic          clear,
    input  logic          wr,
    input  logic [PW-1:0] wdata,
    output logic          tick
);

    logic [PW-1:0] period_q;
    logic [PW-1:0] cnt_q;
    logic          tick_q;

    // a write restarts the channel and suppresses any expiry landing on the same edge
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            period_q <= '0;
            cnt_q    <= '0;
            tick_q   <= 1'b0;
        end else begin
            tick_q <= 1'b0;
            if (wr) begin
                period_q <= wdata;
                cnt_q    <= '0;
            end else if (clear) begin
                cnt_q <= '0;
            end else if (base_event) begin
                if (period_q == '0) begin
                    cnt_q <= '0;
                end else if (cnt_q == period_q - 1'b1) begin
                    cnt_q  <= '0;
                    tick_q <= 1'b1;
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                end
            end
        end
    end

    assign tick = tick_q;

endmodule

// File: rtl/game_tick_scheduler.sv
// Game timebase: prescaler to a base tick, run/pause/step/stop sequencing and
// fan-out to CH programmable tick channels.
module game_tick_scheduler
    import game_pkg::*;
#(
    parameter int PRESCALE_M = PRESCALE_M_DEFAULT,
    parameter int PRESCALE_N = PRESCALE_N_DEFAULT,
    parameter int CH         = 4,
    parameter int PW         = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    game_tick_scheduler_if.slave  bus
);

    localparam int CW = (CH > 1) ? $clog2(CH) : 1;
    localparam logic [PRESCALE_N-1:0] PRESC_LAST = PRESCALE_N'(PRESCALE_M - 1);

    state_e                state_q, state_d;
    logic [PRESCALE_N-1:0] presc_q, presc_d;
    logic                  base_tick_q;
    logic                  base_event;
    logic                  clear;
    logic [CH-1:0]         tick_w;

    // base events look at the registered state, so a pause on the wrap cycle still fires
    always_comb begin
        state_d    = next_state(state_q, bus.start, bus.pause, bus.stop);
        base_event = ((state_q == ST_RUN) && (presc_q == PRESC_LAST)) ||
                     ((state_q == ST_PAUSE) && bus.step);
        clear      = (state_q == ST_IDLE);
        presc_d    = presc_q;
        case (state_q)
            ST_IDLE: presc_d = '0;
            ST_RUN:  presc_d = (presc_q == PRESC_LAST) ? '0 : presc_q + 1'b1;
            default: presc_d = presc_q;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            presc_q     <= '0;
            base_tick_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            presc_q     <= presc_d;
            base_tick_q <= base_event;
        end
    end

    // an out-of-range cfg_ch matches no channel and is dropped
    for (genvar i = 0; i < CH; i++) begin : g_ch
        tick_channel #(.PW(PW)) u_ch (
            .clk        (clk),
            .reset      (reset),
            .base_event (base_event),
            .clear      (clear),
            .wr         (bus.cfg_we && (bus.cfg_ch == CW'(i))),
            .wdata      (bus.cfg_period),
            .tick       (tick_w[i])
        );
    end

    assign bus.state     = state_q;
    assign bus.base_tick = base_tick_q;
    assign bus.tick      = tick_w;

endmodule

// File: tb/tb_game_tick_scheduler.sv
// Scoreboard bench for game_tick_scheduler with a 4-cycle prescaler and four
// channels; expected tick events are queued by stimulus and matched by a monitor.
module tb_game_tick_scheduler;
    import game_pkg::*;

    typedef struct {
        int         cyc;
        logic [3:0] tk;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    int   edge_n = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];

    game_tick_scheduler_if #(.CH(4), .PW(8)) bus ();

    game_tick_scheduler #(
        .PRESCALE_M (4),
        .PRESCALE_N (3),
        .CH         (4),
        .PW         (8)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) edge_n <= edge_n + 1;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", nm, act, exp, edge_n);
        end
    endtask

    task automatic exp_ev(input int c, input logic [3:0] tk);
        exp_t x;
        x.cyc = c;
        x.tk  = tk;
        exp_q.push_back(x);
    endtask

    // called at a falling edge; inputs are sampled at the next rising edge, returned as e
    task automatic drive(input logic st, input logic pa, input logic sp, input logic stp,
                         input logic we, input logic [1:0] ch, input logic [7:0] per,
                         output int e);
        bus.start      = st;
        bus.pause      = pa;
        bus.stop       = sp;
        bus.step       = stp;
        bus.cfg_we     = we;
        bus.cfg_ch     = ch;
        bus.cfg_period = per;
        e = edge_n + 1;
        @(negedge clk);
        bus.start  = 1'b0;
        bus.pause  = 1'b0;
        bus.stop   = 1'b0;
        bus.step   = 1'b0;
        bus.cfg_we = 1'b0;
    endtask

    task automatic wait_until(input int k);
        while (edge_n < k) @(negedge clk);
    endtask

    // monitor: every output pulse must match the head of the queue in cycle and value
    always @(negedge clk) begin
        exp_t x;
        if (exp_q.size() > 0 && exp_q[0].cyc < edge_n) begin
            x = exp_q.pop_front();
            checks++;
            errors++;
            $display("FAIL missing_event: got none expected base_tick tick=%b at edge %0d", x.tk, x.cyc);
        end
        if (bus.base_tick || bus.tick != 4'b0000) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_event: got base_tick=%b tick=%b at edge %0d expected none",
                         bus.base_tick, bus.tick, edge_n);
            end else begin
                x = exp_q.pop_front();
                if (x.cyc != edge_n || bus.base_tick !== 1'b1 || bus.tick !== x.tk) begin
                    errors++;
                    $display("FAIL event: got base_tick=%b tick=%b at edge %0d expected base_tick=1 tick=%b at edge %0d",
                             bus.base_tick, bus.tick, edge_n, x.tk, x.cyc);
                end
            end
        end
    end

    initial begin
        int e, d, p, r;
        reset          = 1'b1;
        bus.start      = 1'b0;
        bus.pause      = 1'b0;
        bus.stop       = 1'b0;
        bus.step       = 1'b0;
        bus.cfg_we     = 1'b0;
        bus.cfg_ch     = 2'd0;
        bus.cfg_period = 8'd0;
        repeat (2) @(negedge clk);
        check("reset_state", 32'(bus.state), 32'(ST_IDLE));
        check("reset_base_tick", 32'(bus.base_tick), 32'd0);
        check("reset_tick", 32'(bus.tick), 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // free-running base tick, no channels configured
        drive(1, 0, 0, 0, 0, 2'd0, 8'd0, e);
        check("s1_run", 32'(bus.state), 32'(ST_RUN));
        exp_ev(e + 4, 4'b0000);
        exp_ev(e + 8, 4'b0000);
        exp_ev(e + 12, 4'b0000);
        wait_until(e + 13);
        drive(0, 0, 1, 0, 0, 2'd0, 8'd0, d);
        check("s1_idle", 32'(bus.state), 32'(ST_IDLE));
        drive(0, 0, 0, 1, 0, 2'd0, 8'd0, d);
        check("idle_step_ignored", 32'(bus.state), 32'(ST_IDLE));
        wait_until(d + 6);

        // ch0 period 3, ch1 period 1
        drive(0, 0, 0, 0, 1, 2'd0, 8'd3, d);
        drive(0, 0, 0, 0, 1, 2'd1, 8'd1, d);
        drive(1, 0, 0, 0, 0, 2'd0, 8'd0, e);
        exp_ev(e + 4, 4'b0010);
        exp_ev(e + 8, 4'b0010);
        exp_ev(e + 12, 4'b0011);
        exp_ev(e + 16, 4'b0010);
        exp_ev(e + 20, 4'b0010);
        exp_ev(e + 24, 4'b0011);
        wait_until(e + 25);
        drive(0, 0, 1, 0, 0, 2'd0, 8'd0, d);
        check("s2_idle", 32'(bus.state), 32'(ST_IDLE));
        wait_until(d + 3);

        // pause at prescaler 2, single step, resume
        drive(1, 0, 0, 0, 0, 2'd0, 8'd0, e);
        wait_until(e + 1);
        drive(0, 1, 0, 0, 0, 2'd0, 8'd0, d);
        check("s3_pause", 32'(bus.state), 32'(ST_PAUSE));
        wait_until(e + 8);
        drive(0, 0, 0, 1, 0, 2'd0, 8'd0, p);
        exp_ev(p, 4'b0010);
        check("s3_still_paused", 32'(bus.state), 32'(ST_PAUSE));
        wait_until(p + 4);
        drive(1, 0, 0, 0, 0, 2'd0, 8'd0, r);
        check("s3_resume", 32'(bus.state), 32'(ST_RUN));
        exp_ev(r + 2, 4'b0010);
        exp_ev(r + 6, 4'b0011);
        wait_until(r + 7);
        drive(0, 0, 1, 0, 0, 2'd0, 8'd0, d);
        wait_until(d + 3);

        // rewrite ch0 to period 5 on the edge where it would expire
        drive(1, 0, 0, 0, 0, 2'd0, 8'd0, e);
        exp_ev(e + 4, 4'b0010);
        exp_ev(e + 8, 4'b0010);
        exp_ev(e + 12, 4'b0010);
        exp_ev(e + 16, 4'b0010);
        exp_ev(e + 20, 4'b0010);
        exp_ev(e + 24, 4'b0010);
        exp_ev(e + 28, 4'b0010);
        exp_ev(e + 32, 4'b0011);
        wait_until(e + 11);
        drive(0, 0, 0, 0, 1, 2'd0, 8'd5, d);
        wait_until(e + 33);
        drive(0, 0, 1, 0, 0, 2'd0, 8'd0, d);
        wait_until(d + 3);

        // stop+pause together mid-count, restart reproduces fresh timing
        drive(0, 0, 0, 0, 1, 2'd0, 8'd3, d);
        drive(1, 0, 0, 0, 0, 2'd0, 8'd0, e);
        exp_ev(e + 4, 4'b0010);
        exp_ev(e + 8, 4'b0010);
        wait_until(e + 9);
        drive(0, 1, 1, 0, 0, 2'd0, 8'd0, d);
        check("s5_stop_wins", 32'(bus.state), 32'(ST_IDLE));
        wait_until(d + 3);
        drive(1, 0, 0, 0, 0, 2'd0, 8'd0, e);
        exp_ev(e + 4, 4'b0010);
        exp_ev(e + 8, 4'b0010);
        exp_ev(e + 12, 4'b0011);
        wait_until(e + 11);
        drive(0, 0, 1, 0, 0, 2'd0, 8'd0, d);
        check("s5_stop_on_event", 32'(bus.state), 32'(ST_IDLE));
        wait_until(d + 4);

        // pause on the wrap cycle still lets that base event fire
        drive(1, 0, 0, 0, 0, 2'd0, 8'd0, e);
        exp_ev(e + 4, 4'b0010);
        wait_until(e + 3);
        drive(0, 1, 0, 0, 0, 2'd0, 8'd0, d);
        check("wrap_pause", 32'(bus.state), 32'(ST_PAUSE));
        wait_until(d + 4);
        drive(0, 0, 1, 0, 0, 2'd0, 8'd0, d);
        check("pause_stop", 32'(bus.state), 32'(ST_IDLE));
        wait_until(d + 3);

        // asynchronous reset right after a base event clears outputs and periods
        drive(1, 0, 0, 0, 0, 2'd0, 8'd0, e);
        exp_ev(e + 4, 4'b0010);
        wait_until(e + 7);
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("async_state", 32'(bus.state), 32'(ST_IDLE));
        check("async_base_tick", 32'(bus.base_tick), 32'd0);
        check("async_tick", 32'(bus.tick), 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        drive(1, 0, 0, 0, 0, 2'd0, 8'd0, e);
        check("post_reset_run", 32'(bus.state), 32'(ST_RUN));
        exp_ev(e + 4, 4'b0000);
        exp_ev(e + 8, 4'b0000);
        wait_until(e + 10);
        check("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/game_tick_scheduler.md
Name: game_tick_scheduler

Overview:
Central timing controller for game logic. A prescaler divides clk down to a base game tick, which the block fans out to CH independently programmable tick channels (enemy step, bullet step, spawn, animation). A run/pause/step/stop state machine sequences the whole timebase, so gameplay can freeze on pause and be single-stepped for debug.

Parameters:
PRESCALE_M, 500000, clk cycles per base tick (100 Hz at 50 MHz); must be >= 2
PRESCALE_N, 19, prescaler counter width; 2^N >= PRESCALE_M
CH, 4, number of tick channels
PW, 8, channel period register and counter width

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
start  in  1  pulse: IDLE->RUN or PAUSE->RUN
pause  in  1  pulse: RUN->PAUSE
stop  in  1  pulse: any state->IDLE
step  in  1  pulse: in PAUSE, forces one base event
cfg_we  in  1  write strobe for a channel period
cfg_ch  in  $clog2(CH)  channel index for write
cfg_period  in  PW  period in base ticks; 0 = channel disabled
state  out  2  current state (encoding in package)
base_tick  out  1  registered one-cycle pulse per base event
tick  out  CH  registered one-cycle pulse per channel expiry

Behaviour:
- Reset (async): state=IDLE, prescaler=0, all channel counters=0, all periods=0, base_tick=0, tick=0. Takes effect immediately, mid-operation included.
- State machine. Priority on simultaneous commands: stop > pause > start.
  - IDLE: start -> RUN.
  - RUN: pause -> PAUSE.
  - PAUSE: start -> RUN.
  - stop from any state -> IDLE.
  - Commands not valid in the current state are ignored.
- IDLE: prescaler and channel counters are cleared to 0 every cycle. Periods are retained. No base events occur.
- Prescaler: in RUN, counts 0..PRESCALE_M-1 and wraps to 0. In PAUSE, holds its value.
- Base event, evaluated on the current registered state:
  - (state==RUN and prescaler==PRESCALE_M-1), or (state==PAUSE and step).
  - step does not move the prescaler.
  - A pause arriving in the same cycle as the wrap still lets that base event fire.
- Channel i, on a base event:
  - If period[i]==0: counter held at 0, no tick.
  - Else if cnt[i]==period[i]-1: cnt[i] <= 0 and the tick fires.
  - Else: cnt[i] <= cnt[i]+1.
  - Arithmetic is unsigned PW bits. period=1 ticks on every base event.
- Latency: base_tick and tick[i] are registered. Each is high for exactly one clk, in the cycle after the base event.
- Config write (cfg_we):
  - period[cfg_ch] <= cfg_period and cnt[cfg_ch] <= 0 at the same edge.
  - The write overrides a coincident expiry on that channel: no tick and counter 0. Other channels are unaffected.
  - Writes are accepted in every state.
  - An out-of-range cfg_ch (CH not a power of 2) is ignored.
- After a stop, outputs return to 0 one cycle later. A tick registered in the stop cycle still appears.

Decomposition:
- Shared package (game_pkg):
  - state localparams ST_IDLE=2'b00, ST_RUN=2'b01, ST_PAUSE=2'b10.
  - Default PRESCALE_M / PRESCALE_N values for the 50 MHz board.
- One sub-module, tick_channel: period register, counter and tick register for one channel, instantiated CH times via generate.
  - Inputs: base_event, clear, wr, wdata.
  - Output: tick.

Test Plan:
All scenarios use PRESCALE_M=4, CH=4, PW=8. Cycle numbers count from the start edge.
1. Reset, then start, no config -> state=RUN; base_tick high in cycles 4, 8, 12, ...; tick=4'b0000 throughout.
2. Write ch0 period=3 and ch1 period=1, then start -> tick[1] high in cycles 4, 8, 12, ...; tick[0] high in cycles 12, 24, ...; each pulse is 1 clk wide.
3. Pause in cycle 2 -> prescaler frozen at 2, no base_tick. Then:
   - step pulse -> base_tick exactly 1 cycle later and prescaler still 2.
   - start -> next base_tick 2 cycles after resume.
4. ch0 period=3, write period=5 in the cycle where cnt0=2 and a base event occurs -> no tick[0]; next tick[0] comes 5 base ticks later.
5. stop and pause asserted together in RUN -> state=IDLE; prescaler and counters=0; periods kept; a later start reproduces the scenario-2 timing.
6. Assert reset asynchronously mid-RUN between clock edges -> state, base_tick and tick go to 0 immediately; periods=0 afterwards.
